// File: rtl/eq_access_ctrl.sv
// Event-queue access controller: sequences insert/extract commands on the
// queue's op/cs interface, one command at a time, with round-robin arbitration.

`ifndef INSERT_CMD
`define INSERT_CMD 1'b1
`endif
`ifndef EXTRACT_CMD
`define EXTRACT_CMD 1'b0
`endif

module eq_access_ctrl #(
    parameter int data_wd  = 32,
    parameter int q_add_wd = 5,
    parameter int hi       = 15,
    parameter int lo       = 0,
    parameter int cnt_wd   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [data_wd-1:0]  in_data,
    output logic                in_ready,
    input  logic [hi-lo:0]      now_time,
    output logic                out_valid,
    output logic [data_wd-1:0]  out_data,
    input  logic                out_ready,
    output logic [data_wd-1:0]  eq_EV_in,
    output logic                eq_op,
    output logic                eq_cs,
    input  logic [data_wd-1:0]  eq_EV_out,
    input  logic                eq_dv,
    input  logic                eq_full,
    input  logic                eq_empty,
    input  logic                eq_busy_for_rd,
    input  logic                eq_busy_for_wr,
    input  logic [q_add_wd-1:0] eq_length,
    output logic [cnt_wd-1:0]   ins_cnt,
    output logic [cnt_wd-1:0]   ext_cnt
);

    typedef enum logic [1:0] {IDLE, CMD, GUARD} state_t;

    state_t               state_q, state_d;
    logic                 op_q, op_d;
    logic                 last_grant_q, last_grant_d;
    logic [data_wd-1:0]   hold_q, hold_d;
    logic                 ins_pend_q, ins_pend_d;
    logic                 out_valid_q, out_valid_d;
    logic [data_wd-1:0]   out_data_q, out_data_d;
    logic [cnt_wd-1:0]    ins_cnt_q, ins_cnt_d;
    logic [cnt_wd-1:0]    ext_cnt_q, ext_cnt_d;

    logic ins_ok;
    logic ext_ok;
    logic head_due;
    logic unused_len;

    // Occupancy is informational only; nothing in the control path uses it.
    assign unused_len = ^eq_length;

    assign head_due = (eq_EV_out[hi:lo] <= now_time);
    assign ins_ok   = ins_pend_q && !eq_full && !eq_busy_for_wr;
    assign ext_ok   = eq_dv && !eq_empty && !eq_busy_for_rd && !out_valid_q && head_due;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        last_grant_d = last_grant_q;
        hold_d       = hold_q;
        ins_pend_d   = ins_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        ins_cnt_d    = ins_cnt_q;
        ext_cnt_d    = ext_cnt_q;

        if (in_valid && !ins_pend_q) begin
            hold_d     = in_data;
            ins_pend_d = 1'b1;
        end
        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ins_ok && ext_ok) begin
                    op_d    = (last_grant_q == `INSERT_CMD) ? `EXTRACT_CMD : `INSERT_CMD;
                    state_d = CMD;
                end else if (ins_ok) begin
                    op_d    = `INSERT_CMD;
                    state_d = CMD;
                end else if (ext_ok) begin
                    op_d    = `EXTRACT_CMD;
                    state_d = CMD;
                end
            end
            CMD: begin
                // Strobe is committed once granted; flags are not re-checked here.
                state_d      = GUARD;
                last_grant_d = op_q;
                if (op_q == `INSERT_CMD) begin
                    ins_pend_d = 1'b0;
                    if (!(&ins_cnt_q)) ins_cnt_d = ins_cnt_q + 1'b1;
                end else begin
                    out_data_d  = eq_EV_out;
                    out_valid_d = 1'b1;
                    if (!(&ext_cnt_q)) ext_cnt_d = ext_cnt_q + 1'b1;
                end
            end
            // Queue status is registered on its side; give it one cycle to settle.
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            op_q         <= `EXTRACT_CMD;
            last_grant_q <= `EXTRACT_CMD;
            hold_q       <= '0;
            ins_pend_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            ins_cnt_q    <= '0;
            ext_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            ins_pend_q   <= ins_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            ins_cnt_q    <= ins_cnt_d;
            ext_cnt_q    <= ext_cnt_d;
        end
    end

    assign in_ready  = !ins_pend_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign eq_cs     = (state_q == CMD);
    assign eq_op     = (state_q == CMD) ? op_q : `EXTRACT_CMD;
    assign eq_EV_in  = (state_q == CMD && op_q == `INSERT_CMD) ? hold_q : '0;
    assign ins_cnt   = ins_cnt_q;
    assign ext_cnt   = ext_cnt_q;

    a_cs_gap: assert property (@(posedge clk) disable iff (!rst) eq_cs |=> !eq_cs);

endmodule

// File: tb/tb_eq_access_ctrl.sv
// Scoreboard bench for eq_access_ctrl: directed stimulus pushes expected queue
// commands and consumer outputs; negedge monitors pop and compare.

`ifndef INSERT_CMD
`define INSERT_CMD 1'b1
`endif
`ifndef EXTRACT_CMD
`define EXTRACT_CMD 1'b0
`endif

module tb_eq_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic [15:0] now_time = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
    logic [31:0] eq_EV_in;
    logic        eq_op;
    logic        eq_cs;
    logic [31:0] eq_EV_out = '0;
    logic        eq_dv = 1'b0;
    logic        eq_full = 1'b0;
    logic        eq_empty = 1'b1;
    logic        eq_busy_for_rd = 1'b0;
    logic        eq_busy_for_wr = 1'b0;
    logic [4:0]  eq_length = '0;
    logic [15:0] ins_cnt;
    logic [15:0] ext_cnt;

    eq_access_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .now_time(now_time),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .eq_EV_in(eq_EV_in), .eq_op(eq_op), .eq_cs(eq_cs),
        .eq_EV_out(eq_EV_out), .eq_dv(eq_dv), .eq_full(eq_full), .eq_empty(eq_empty),
        .eq_busy_for_rd(eq_busy_for_rd), .eq_busy_for_wr(eq_busy_for_wr),
        .eq_length(eq_length), .ins_cnt(ins_cnt), .ext_cnt(ext_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] data;
        int          cyc;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] out_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        prev_cs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_cmd(input logic op, input logic [31:0] data, input int at);
        cmd_t c;
        c.op = op; c.data = data; c.cyc = at;
        cmd_q.push_back(c);
    endtask

    // Command and consumer monitors
    always @(negedge clk) begin
        if (!rst) begin
            prev_cs = 1'b0;
        end else begin
            if (eq_cs) begin
                chk("cs_gap", {63'd0, prev_cs}, 64'd0);
                if (cmd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cs: got op=%0b data=%0h expected no command (cycle %0d)",
                             eq_op, eq_EV_in, cyc);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    chk("cmd_op", {63'd0, eq_op}, {63'd0, e.op});
                    chk("cmd_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.op == `INSERT_CMD) chk("cmd_ev_in", {32'd0, eq_EV_in}, {32'd0, e.data});
                end
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0h expected no output", out_data);
                end else begin
                    chk("out_data", {32'd0, out_data}, {32'd0, out_q.pop_front()});
                end
            end
            prev_cs = eq_cs;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(3);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_cs", {63'd0, eq_cs}, 64'd0);
        chk("rst_op", {63'd0, eq_op}, {63'd0, `EXTRACT_CMD});
        chk("rst_ev_in", {32'd0, eq_EV_in}, 64'd0);
        chk("rst_ins_cnt", {48'd0, ins_cnt}, 64'd0);
        chk("rst_ext_cnt", {48'd0, ext_cnt}, 64'd0);
        rst = 1'b1;
        step(2);

        // Single insert: strobe one cycle after load
        in_valid = 1'b1; in_data = 32'h0000_0005;
        step();
        in_valid = 1'b0;
        exp_cmd(`INSERT_CMD, 32'h0000_0005, cyc + 1);
        chk("ins_in_ready_low", {63'd0, in_ready}, 64'd0);
        step(2);
        chk("ins_cnt_1", {48'd0, ins_cnt}, 64'd1);
        chk("ins_in_ready_back", {63'd0, in_ready}, 64'd1);
        step(2);

        // Time gating: head TIME 0x10 vs now 0x0F then 0x10
        eq_EV_out = 32'h0000_0010; eq_dv = 1'b1; eq_empty = 1'b0; now_time = 16'h000F;
        step(5);
        chk("gate_ext_cnt", {48'd0, ext_cnt}, 64'd0);
        now_time = 16'h0010;
        exp_cmd(`EXTRACT_CMD, 32'h0000_0010, cyc + 1);
        out_q.push_back(32'h0000_0010);
        step();
        eq_dv = 1'b0; eq_empty = 1'b1;
        chk("gate_ov_not_yet", {63'd0, out_valid}, 64'd0);
        step();
        chk("gate_ov", {63'd0, out_valid}, 64'd1);
        chk("gate_out_data", {32'd0, out_data}, 64'h10);
        chk("gate_ext_cnt_1", {48'd0, ext_cnt}, 64'd1);
        step(2);

        // Back-pressure: one extract only while out_ready=0
        out_ready = 1'b0; eq_EV_out = 32'hAB00_0003; eq_dv = 1'b1; eq_empty = 1'b0;
        exp_cmd(`EXTRACT_CMD, 32'hAB00_0003, cyc + 1);
        out_q.push_back(32'hAB00_0003);
        step(2);
        eq_EV_out = 32'hCD00_0004;
        step(6);
        chk("bp_ov_held", {63'd0, out_valid}, 64'd1);
        chk("bp_data_stable", {32'd0, out_data}, 64'hAB00_0003);
        chk("bp_ext_cnt", {48'd0, ext_cnt}, 64'd2);
        out_ready = 1'b1;
        exp_cmd(`EXTRACT_CMD, 32'hCD00_0004, cyc + 2);
        out_q.push_back(32'hCD00_0004);
        step(2);
        eq_dv = 1'b0; eq_empty = 1'b1;
        step(3);
        chk("bp_ext_cnt_3", {48'd0, ext_cnt}, 64'd3);

        // Tie arbitration: INS, EXT, INS, EXT spaced 3 cycles, then a lone INS
        now_time = 16'hFFFF; eq_EV_out = 32'h0000_0222;
        in_valid = 1'b1; in_data = 32'h0000_0111;
        step();
        eq_dv = 1'b1; eq_empty = 1'b0; in_data = 32'h0000_0333;
        exp_cmd(`INSERT_CMD,  32'h0000_0111, cyc + 1);
        exp_cmd(`EXTRACT_CMD, 32'h0000_0222, cyc + 4);
        exp_cmd(`INSERT_CMD,  32'h0000_0333, cyc + 7);
        exp_cmd(`EXTRACT_CMD, 32'h0000_0222, cyc + 10);
        exp_cmd(`INSERT_CMD,  32'h0000_0555, cyc + 13);
        out_q.push_back(32'h0000_0222);
        out_q.push_back(32'h0000_0222);
        step(3);
        in_data = 32'h0000_0555;
        step(6);
        in_valid = 1'b0;
        step();
        eq_dv = 1'b0; eq_empty = 1'b1;
        step(5);
        chk("rr_ins_cnt", {48'd0, ins_cnt}, 64'd4);
        chk("rr_ext_cnt", {48'd0, ext_cnt}, 64'd5);

        // Full and busy_for_wr hold off the insert
        eq_full = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0777;
        step();
        in_valid = 1'b0;
        step(5);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_ins_cnt", {48'd0, ins_cnt}, 64'd4);
        eq_full = 1'b0; eq_busy_for_wr = 1'b1;
        step(4);
        eq_busy_for_wr = 1'b0;
        exp_cmd(`INSERT_CMD, 32'h0000_0777, cyc + 1);
        step(3);
        chk("busy_ins_cnt", {48'd0, ins_cnt}, 64'd5);
        chk("busy_in_ready", {63'd0, in_ready}, 64'd1);
        step(2);

        // Reset in the middle of a command
        in_valid = 1'b1; in_data = 32'h0000_0999;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_cs_high", {63'd0, eq_cs}, 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cs", {63'd0, eq_cs}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_ov", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ins_cnt", {48'd0, ins_cnt}, 64'd0);
        chk("mid_rst_ext_cnt", {48'd0, ext_cnt}, 64'd0);
        step(2);
        rst = 1'b1;
        step(4);
        chk("post_rst_idle_cs", {63'd0, eq_cs}, 64'd0);
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        chk("out_q_drained", 64'(out_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eq_access_ctrl.md
Name: eq_access_ctrl

Overview:
Initiator-side controller for the event queue's op/cs command interface. It accepts events from a producer over a valid/ready handshake and issues insert commands. It issues extract commands whenever the queue head's TIME field is due (≤ now_time) and presents each extracted event to a consumer over valid/ready. It sequences one queue command at a time, honouring the queue's busy, full, empty and dv indications, and arbitrates insert against extract round-robin.

Parameters:
data_wd, 32, width of one event entry
q_add_wd, 5, width of the queue length field
hi, 15, TIME field high bit within an event
lo, 0, TIME field low bit within an event
cnt_wd, 16, width of the insert/extract statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  producer event valid
in_data  in  data_wd  producer event
in_ready  out  1  input holding register empty
now_time  in  hi-lo+1  current simulation time
out_valid  out  1  extracted event valid
out_data  out  data_wd  extracted event
out_ready  in  1  consumer accepts out_data
eq_EV_in  out  data_wd  event to the queue
eq_op  out  1  `INSERT_CMD or `EXTRACT_CMD
eq_cs  out  1  queue command strobe
eq_EV_out  in  data_wd  queue head event
eq_dv  in  1  queue head valid
eq_full  in  1  queue full
eq_empty  in  1  queue empty
eq_busy_for_rd  in  1  extract not allowed
eq_busy_for_wr  in  1  insert not allowed
eq_length  in  q_add_wd  queue occupancy (status pass-through only)
ins_cnt  out  cnt_wd  inserts issued, saturating
ext_cnt  out  cnt_wd  extracts issued, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_data=0; eq_cs=0; eq_op=`EXTRACT_CMD; eq_EV_in=0; ins_cnt=0; ext_cnt=0; last_grant=EXTRACT, so insert wins the first tie. Reset mid-command drops the command. The holding register and output register are cleared.
- Input holding register: loads in_data when in_valid && in_ready; in_ready = !ins_pend. ins_pend clears in the cycle its insert command is issued. A new input can be accepted in the cycle after issue.
- Insert eligible (ins_ok): ins_pend && !eq_full && !eq_busy_for_wr.
- Extract eligible (ext_ok): eq_dv && !eq_empty && !eq_busy_for_rd && !out_valid && eq_EV_out[hi:lo] <= now_time. The comparison is unsigned.
- FSM, 3 states:
  - IDLE:
    - If only one of ins_ok/ext_ok is set, go to CMD with that op.
    - If both are set, grant the op opposite to last_grant.
    - If neither is set, stay in IDLE.
  - CMD (exactly 1 cycle):
    - eq_cs=1 and eq_op=granted op.
    - Insert: eq_EV_in = holding register.
    - Extract: eq_EV_out is captured into out_data this cycle, and out_valid is set at the next edge.
    - last_grant is updated; the matching counter increments, saturating at all-ones.
    - Go to GUARD.
  - GUARD (exactly 1 cycle): eq_cs=0. Busy/dv/full flags are ignored to cover the queue's registered status latency. Go to IDLE.
- Throughput: at most one command per 3 cycles. Latency from an eligible, idle condition to eq_cs is 1 cycle.
- eq_cs is never high for two consecutive cycles. eq_cs is never asserted with eq_op=`INSERT_CMD while eq_full=1.
- Output register:
  - out_valid clears on out_valid && out_ready.
  - A new extract is not issued while out_valid=1, so there is no overwrite.
  - out_data is held stable while out_valid && !out_ready.
- Eligibility is re-evaluated only in IDLE. A flag change during CMD does not abort the strobe.
- Simultaneous in_valid acceptance and an insert issue of the previous entry is impossible, because in_ready=0 while pending.
- eq_length is not used for control.

Test Plan:
1. Reset: drive rst=0 mid-CMD → eq_cs drops to 0 immediately; in_ready=1; out_valid=0; counters read 0.
2. Single insert: in_valid with in_data=0x0000_0005 into an empty queue → eq_cs=1 with `INSERT_CMD and eq_EV_in=0x0000_0005 exactly 1 cycle after the load; ins_cnt=1; in_ready returns to 1.
3. Time gating: eq_dv=1, head TIME=0x0010, now_time=0x000F → no extract. now_time=0x0010 → `EXTRACT_CMD strobe; out_data equals the head; out_valid=1 on the next cycle.
4. Back-pressure: out_ready=0 with due events queued → exactly one extract; out_data stable; no further eq_cs until out_ready=1.
5. Tie arbitration: ins_ok and ext_ok held true continuously → op sequence INS, EXT, INS, EXT, with commands spaced 3 cycles apart.
6. Full/busy: eq_full=1 with pending input → no insert and in_ready=0. eq_busy_for_wr pulsed for 4 cycles → insert is delayed until the pulse ends.
